// File: rtl/code_loader.sv
// code_loader: parses a byte stream into fixed-width code words and writes
// them into a line-addressed code store.
//
// Stream format: 16-bit line count N (little-endian), then N words, each
// 2 bytes little-endian. Only the low code_size bits of each word are kept.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   start         in   one-cycle load request (ignored while busy)
//   in_valid      in   byte valid
//   in_data       in   byte payload [7:0]
//   in_ready      out  byte ready (a byte moves when in_valid & in_ready)
//   is_write      out  store write strobe, one cycle per word
//   write_line    out  store write address [31:0]
//   write_data    out  store write word [code_size-1:0]
//   core_reset    out  one-cycle pulse after a successful load
//   busy          out  load in progress
//   done          out  last load completed, held until start/reset
//   error         out  last load aborted (N too large), held until start/reset
//   lines_loaded  out  words written by the current/last load [31:0]
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start after reset
// LEN_LO  | expecting low byte of line count
// LEN_HI  | expecting high byte of line count, then range check
// DATA_LO | expecting low byte of next word
// DATA_HI | expecting high byte of next word, then write
// DONE    | load finished, done held
// ERROR   | line count exceeded capacity, error held
module code_loader #(
  parameter int code_size     = 12,
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          lines_loaded
);

  localparam logic [31:0] CAPACITY = 32'(max_code_line + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_DONE, S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [7:0]             lo_q, lo_d;
  logic                   is_write_q, is_write_d;
  logic [31:0]            write_line_q, write_line_d;
  logic [code_size-1:0]   write_data_q, write_data_d;
  logic                   core_reset_q, core_reset_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [31:0]            lines_loaded_q, lines_loaded_d;
  logic                   busy_w;
  logic                   xfer;
  logic [31:0]            n_full;

  assign busy_w = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                  (state_q == S_DATA_LO) || (state_q == S_DATA_HI);
  assign xfer   = in_valid && busy_w;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    lo_d           = lo_q;
    is_write_d     = 1'b0;
    write_line_d   = write_line_q;
    write_data_d   = write_data_q;
    core_reset_d   = 1'b0;
    done_d         = done_q;
    error_d        = error_q;
    lines_loaded_d = lines_loaded_q;
    // full count as it will be once the high byte lands this cycle
    n_full         = {16'd0, in_data, len_q[7:0]};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d        = S_LEN_LO;
          done_d         = 1'b0;
          error_d        = 1'b0;
          lines_loaded_d = 32'd0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          if (n_full > CAPACITY) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (n_full == 32'd0) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b1;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          // lines_loaded doubles as the next write index
          is_write_d     = 1'b1;
          write_line_d   = lines_loaded_q;
          write_data_d   = code_size'({in_data, lo_q});
          lines_loaded_d = lines_loaded_q + 32'd1;
          if ({16'd0, len_q} == lines_loaded_q + 32'd1) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b1;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      lo_q           <= '0;
      is_write_q     <= 1'b0;
      write_line_q   <= '0;
      write_data_q   <= '0;
      core_reset_q   <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      lines_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      lo_q           <= lo_d;
      is_write_q     <= is_write_d;
      write_line_q   <= write_line_d;
      write_data_q   <= write_data_d;
      core_reset_q   <= core_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
      lines_loaded_q <= lines_loaded_d;
    end
  end

  assign in_ready     = busy_w;
  assign busy         = busy_w;
  assign is_write     = is_write_q;
  assign write_line   = write_line_q;
  assign write_data   = write_data_q;
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign lines_loaded = lines_loaded_q;

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 Parameter code_size, default 12: width in bits of one code word.
REQ-002 Parameter max_code_line, default 100: highest storage line index, so capacity is max_code_line+1 lines.
REQ-003 clk  input  1  single clock; all logic on the posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers on a cycle with in_valid and in_ready both high.
REQ-009 is_write  output  1  storage write strobe.
REQ-010 write_line  output  32  storage write address.
REQ-011 write_data  output  code_size  storage write word.
REQ-012 core_reset  output  1  one-cycle pulse that resets the storage read pointer after a successful load.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed successfully; held until the next start or reset.
REQ-015 error  output  1  last load aborted; held until the next start or reset.
REQ-016 lines_loaded  output  32  number of words written by the current or last load.

Function
REQ-017 Stream format: 2-byte line count N (little-endian), then N words, each 2 bytes little-endian; only bits [code_size-1:0] of each word are used and the upper bits are ignored.
REQ-018 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR with start high -> LEN_LO on the next cycle; the same edge clears done, error and lines_loaded.
REQ-020 LEN_LO: on transfer, latch N[7:0] -> LEN_HI.
REQ-021 LEN_HI: on transfer, latch N[15:8], then go to ERROR if N > max_code_line+1, else to DONE if N == 0, else to DATA_LO.
REQ-022 DATA_LO: on transfer, latch the low byte -> DATA_HI.
REQ-023 DATA_HI: on transfer, register a write, then go to DONE if this was word N, else to DATA_LO.
REQ-024 A write is registered as follows: is_write = 1 for exactly the one cycle after the DATA_HI transfer; write_line = current index (first word 0, then incrementing by 1); write_data = {hi,lo}[code_size-1:0]; lines_loaded increments in that same cycle.
REQ-025 in_ready = 1 only in LEN_LO, LEN_HI, DATA_LO and DATA_HI; it is combinational from state.
REQ-026 in_valid low in any state -> no state change, no write, data regs hold; there is no timeout.
REQ-027 Bytes presented while in_ready = 0 are not consumed.
REQ-028 Entry to DONE sets done = 1 and pulses core_reset for exactly one cycle, on the cycle after entry.
REQ-029 Entry to ERROR sets error = 1, issues no write and no core_reset pulse, and leaves storage lines already written untouched.
REQ-030 busy = 1 exactly in LEN_LO, LEN_HI, DATA_LO and DATA_HI.
REQ-031 start while busy is ignored.
REQ-032 start and a final-byte transfer on the same cycle -> the final byte completes normally and start is dropped.
REQ-033 Back-to-back transfers every cycle are sustained with zero bubbles; maximum throughput is one byte per clk.
REQ-034 write_line never exceeds max_code_line.

Reset
REQ-035 reset has priority over all inputs; it is sampled on the posedge.
REQ-036 On reset the block goes to IDLE with in_ready = 0, is_write = 0, write_line = 0, write_data = 0, core_reset = 0, busy = 0, done = 0, error = 0 and lines_loaded = 0.
REQ-037 Reset mid-load abandons the load, suppresses any pending is_write, and clears no storage lines.
REQ-038 After reset release, start on the first cycle is accepted.

Verification
REQ-039 Basic load: start; bytes 03 00 | 34 12 | FF 0F | 01 00, one per cycle -> writes (0,0x234), (1,0xFFF), (2,0x001), each 1-cycle; done = 1, one core_reset pulse, lines_loaded = 3.
REQ-040 Zero length: start; bytes 00 00 -> no is_write; done = 1; core_reset pulsed once; lines_loaded = 0.
REQ-041 Overflow: start; N = 102 (66 00) -> ERROR, error = 1, no writes, in_ready = 0; N = 101 instead -> accepted, last write_line = 100.
REQ-042 Stalls: N = 2, in_valid toggled randomly with gaps of up to 5 cycles -> same writes as the gap-free case, with each strobe exactly one cycle after its high byte.
REQ-043 Reset mid-load: reset asserted after the low byte of word 1 of N = 3 -> no further writes, all outputs at reset values; a subsequent start plus full stream loads normally.
REQ-044 start during busy: start pulsed in DATA_LO -> no restart; the write sequence is unchanged.
